load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised memory access unit for the multicycle RV32I/RV64I core, replacing the datapath's fixed word-only MAR/MDR/data-out register path. It accepts one load or store per request from the control FSM. It drives an aligned-address memory port with byte enables and waits on `mem_resp`. It returns sign- or zero-extended load data or an error code through a one-cycle response pulse.

## Interface
Parameters:
- `XLEN`, 32: data/address width; legal values are 32 and 64. `NBYTE = XLEN/8`, `OFFW = log2(NBYTE)`.
- `TIMEOUT_CYCLES`, 255: maximum number of ACCESS cycles without `mem_resp`; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V load/store `funct3`.
- `req_addr`  in  XLEN  byte address (rs1 + imm).
- `req_wdata`  in  XLEN  store data (rs2).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  XLEN  extended load data. It is 0 for stores and errors.
- `rsp_error`  out  2  error code: 00 ok, 01 misaligned, 10 illegal `funct3`, 11 timeout.
- `mem_address`  out  XLEN  `req_addr` with bits [OFFW-1:0] cleared.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `mem_byte_enable`  out  NBYTE  byte lanes to write.
- `mem_wdata`  out  XLEN  lane-shifted store data.
- `mem_rdata`  in  XLEN  memory read data.
- `mem_resp`  in  1  memory done.

## Operation
States:
- IDLE
  - `req_ready` = 1.
  - On `req_valid`, latch the request and decode it.
  - If `funct3` is illegal or the address is misaligned, go to DONE and make no memory access.
  - Otherwise go to ACCESS.
- ACCESS
  - Hold `mem_read` or `mem_write`, `mem_address`, `mem_byte_enable` and `mem_wdata` stable.
  - On `mem_resp`: capture the formatted load data, set `rsp_error` to 00 and go to DONE.
  - On timeout: set `rsp_error` to 11 and go to DONE.
- DONE
  - `rsp_valid` = 1 for exactly one cycle, then return to IDLE.

Legal `funct3` values:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. When XLEN=64, also 011 LD and 110 LWU.
- Stores: 000 SB, 001 SH, 010 SW. When XLEN=64, also 011 SD.
- Every other value gives error 10. Illegal `funct3` takes priority over misalignment.

Alignment (`off = req_addr[OFFW-1:0]`):
- Bytes are always aligned.
- Half: `off[0]` = 0.
- Word: `off[1:0]` = 0.
- Double: `off[2:0]` = 0.

Formatting:
- `mem_byte_enable = sizemask << off`, where sizemask is 1, 3, F or FF.
- Loads drive `mem_byte_enable` = all ones.
- `mem_wdata = req_wdata << (8*off)`.
- Load data is `mem_rdata >> (8*off)`, truncated to the access size. It is sign-extended for LB/LH/LW (LW when XLEN=64) and zero-extended for LBU/LHU/LWU.

Response hold:
- `rsp_rdata` and `rsp_error` hold their values until the next accepted request's DONE.

Timeout counter:
- Clears on entry to ACCESS and increments on each ACCESS cycle in which `mem_resp` is low.
- If `TIMEOUT_CYCLES` ACCESS cycles pass with no `mem_resp`, go to DONE with error 11. A store may have partially completed; this is not tracked.

## Timing
Reset (`rst_n` low):
- State goes to IDLE immediately.
- `req_ready` = 1; every other output is 0.
- If reset occurs mid-ACCESS, `mem_read`/`mem_write` drop asynchronously and no response is issued.

Memory request outputs:
- All are registered.
- They assert the cycle after acceptance and deassert the cycle after `mem_resp` is sampled.

Latency:
- A request accepted at edge 0 puts ACCESS in cycle 1.
- If `mem_resp` arrives in cycle k (k ≥ 1), `rsp_valid` is high in cycle k+1.
- Error requests (01/10) see `rsp_valid` in cycle 1.

Boundary cases:
- If `mem_resp` and timeout expiry fall in the same cycle, the response wins and the error is 00.
- `mem_resp` is ignored in IDLE and DONE.
- `req_valid` is ignored while `req_ready` = 0, so a back-to-back request is accepted at the earliest in the cycle after DONE.

## Test plan
- Reset:
  - Stimulus: hold `rst_n` low, assert `mem_resp` and `req_valid` randomly.
  - Required: `req_ready` = 1, all other outputs 0, no state change.
- LB sign extension, XLEN=32:
  - Stimulus: LB at addr 0x103, `mem_rdata` = 0x80FF_1234, `mem_resp` in cycle 3.
  - Required: `mem_address` = 0x100; `rsp_valid` in cycle 4 with `rsp_rdata` = 0xFFFF_FF80 and error 00.
- SH lane shift:
  - Stimulus: SH at addr 0x202 with `req_wdata` = 0x0000_BEEF.
  - Required: `mem_byte_enable` = 1100, `mem_wdata` = 0xBEEF_0000, `mem_write` held until `mem_resp`.
- Misaligned and illegal:
  - LW at 0x101 gives error 01 in cycle 1 with no `mem_read`.
  - Load `funct3` 011 at XLEN=32 gives error 10.
  - Store `funct3` 100 gives error 10.
- Timeout, `TIMEOUT_CYCLES`=4:
  - Stimulus: LW, never assert `mem_resp`.
  - Required: `mem_read` high for exactly 4 cycles, then `rsp_error` = 11 and `rsp_rdata` = 0.
  - Repeat with `mem_resp` in the 4th ACCESS cycle: required error 00.
- XLEN=64:
  - LWU at 0x1004 with `mem_rdata` = 0x8000_0001_0000_0000 gives `rsp_rdata` = 0x0000_0000_8000_0001.
  - SD at 0x1008 gives `mem_byte_enable` = 0xFF.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: decodes one RISC-V memory op, drives an aligned byte-enabled memory port, returns extended data.
// Latency: error responses in cycle 1 after acceptance, otherwise one cycle after mem_resp; ready only in IDLE.
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_error,
    output logic [XLEN-1:0]     mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [XLEN/8-1:0]   mem_byte_enable,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_resp
);
    localparam int NBYTE = XLEN / 8;
    localparam int OFFW  = $clog2(NBYTE);
    localparam int CNTW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNTW-1:0] TO_LAST = CNTW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;
    localparam logic [1:0] ERR_TO    = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         f3_q, f3_d;
    logic [2:0]         off_q, off_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [NBYTE-1:0]   be_q, be_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic [1:0]         err_q, err_d;

    logic [2:0]         off;
    logic               legal;
    logic               misaligned;
    logic [7:0]         sizemask;
    logic [7:0]         be_shift;
    logic [XLEN-1:0]    rd_shift;
    logic [63:0]        rd_wide;
    logic [63:0]        rd_ext;
    logic [XLEN-1:0]    load_data;
    logic               timeout_hit;

    assign off = 3'(req_addr[OFFW-1:0]);

    always_comb begin
        legal = 1'b0;
        if (req_write) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b011:                 legal = (XLEN == 64);
                default:                legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = (XLEN == 64);
                default:                                legal = 1'b0;
            endcase
        end
    end

    // Access size lives in funct3[1:0] for every legal load and store.
    always_comb begin
        misaligned = 1'b0;
        sizemask   = 8'h01;
        case (req_funct3[1:0])
            2'b00: begin misaligned = 1'b0;       sizemask = 8'h01; end
            2'b01: begin misaligned = off[0];     sizemask = 8'h03; end
            2'b10: begin misaligned = |off[1:0];  sizemask = 8'h0F; end
            2'b11: begin misaligned = |off;       sizemask = 8'hFF; end
            default: ;
        endcase
    end

    assign be_shift = sizemask << off;

    // Widen to 64 bits so both XLEN variants share one extension table.
    assign rd_shift = mem_rdata >> {off_q, 3'b000};
    assign rd_wide  = 64'(rd_shift);

    always_comb begin
        rd_ext = '0;
        case (f3_q)
            3'b000: rd_ext = {{56{rd_wide[7]}},  rd_wide[7:0]};
            3'b001: rd_ext = {{48{rd_wide[15]}}, rd_wide[15:0]};
            3'b010: rd_ext = {{32{rd_wide[31]}}, rd_wide[31:0]};
            3'b011: rd_ext = rd_wide;
            3'b100: rd_ext = {56'd0, rd_wide[7:0]};
            3'b101: rd_ext = {48'd0, rd_wide[15:0]};
            3'b110: rd_ext = {32'd0, rd_wide[31:0]};
            default: rd_ext = '0;
        endcase
    end

    assign load_data   = rd_ext[XLEN-1:0];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d  = req_funct3;
                    off_d = off;
                    if (!legal) begin
                        state_d = DONE;
                        err_d   = ERR_F3;
                        rdata_d = '0;
                    end else if (misaligned) begin
                        state_d = DONE;
                        err_d   = ERR_ALIGN;
                        rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                        read_d  = !req_write;
                        write_d = req_write;
                        addr_d  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        be_d    = req_write ? be_shift[NBYTE-1:0] : {NBYTE{1'b1}};
                        wdata_d = req_write ? (req_wdata << {off, 3'b000}) : '0;
                    end
                end
            end
            ACCESS: begin
                if (mem_resp || timeout_hit) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    addr_d  = '0;
                    be_d    = '0;
                    wdata_d = '0;
                    // A response in the expiry cycle still counts as success.
                    if (mem_resp) begin
                        err_d   = ERR_OK;
                        rdata_d = write_q ? '0 : load_data;
                    end else begin
                        err_d   = ERR_TO;
                        rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            f3_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign rsp_valid       = (state_q == DONE);
    assign rsp_rdata       = rdata_q;
    assign rsp_error       = err_q;
    assign mem_address     = addr_q;
    assign mem_read        = read_q;
    assign mem_write       = write_q;
    assign mem_byte_enable = be_q;
    assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit instance (timeout 4) and a 64-bit instance (timeout 16) share stimulus;
// expected responses are queued at request time and checked by a response monitor.
module tb_load_store_unit;
    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_rdata;
    logic        mem_resp;

    logic        r32, v32, rd32, wr32;
    logic [31:0] rdata32, addr32, wdata32;
    logic [1:0]  err32;
    logic [3:0]  be32;
    logic        r64, v64, rd64, wr64;
    logic [63:0] rdata64, addr64, wdata64;
    logic [1:0]  err64;
    logic [7:0]  be64;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(r32), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .rsp_valid(v32), .rsp_rdata(rdata32), .rsp_error(err32),
        .mem_address(addr32), .mem_read(rd32), .mem_write(wr32),
        .mem_byte_enable(be32), .mem_wdata(wdata32),
        .mem_rdata(mem_rdata[31:0]), .mem_resp(mem_resp & ~sel)
    );

    load_store_unit #(.XLEN(64), .TIMEOUT_CYCLES(16)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(r64), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v64), .rsp_rdata(rdata64), .rsp_error(err64),
        .mem_address(addr64), .mem_read(rd64), .mem_write(wr64),
        .mem_byte_enable(be64), .mem_wdata(wdata64),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp & sel)
    );

    logic        o_ready, o_valid, o_read, o_write;
    logic [63:0] o_rdata, o_addr, o_wdata;
    logic [1:0]  o_err;
    logic [7:0]  o_be;
    assign o_ready = sel ? r64 : r32;
    assign o_valid = sel ? v64 : v32;
    assign o_read  = sel ? rd64 : rd32;
    assign o_write = sel ? wr64 : wr32;
    assign o_rdata = sel ? rdata64 : 64'(rdata32);
    assign o_addr  = sel ? addr64 : 64'(addr32);
    assign o_wdata = sel ? wdata64 : 64'(wdata32);
    assign o_err   = sel ? err64 : err32;
    assign o_be    = sel ? be64 : 8'(be32);

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(o_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", o_rdata, e.rdata);
                check("rsp_error", 64'(o_err), 64'(e.err));
                check("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // k = ACCESS cycle carrying mem_resp (0 = never); acc = a memory access is expected.
    task automatic do_req(input bit s, input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input int k, input logic [63:0] mrd, input bit acc,
                          input logic [63:0] eaddr, input logic [7:0] ebe, input logic [63:0] ewd,
                          input logic [63:0] erd, input logic [1:0] eerr);
        int   to;
        int   last;
        int   waitc;
        exp_t e;
        to    = s ? 16 : 4;
        waitc = 0;
        @(negedge clk);
        sel = s;
        #1;
        while (!o_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!o_ready) begin
            check("ready_wait", 64'(o_ready), 64'd1);
            return;
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        e.rdata = erd;
        e.err   = eerr;
        e.cyc   = cyc + 1 + (acc ? ((k > 0) ? k : to) : 0);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (!acc) begin
            check("no_access", 64'({o_read, o_write}), 64'd0);
        end else begin
            last = (k > 0) ? k : to;
            for (int j = 1; j <= last; j++) begin
                check("rw_held", 64'({o_read, o_write}), 64'({~wr, wr}));
                if (j == 1) begin
                    check("mem_address", o_addr, eaddr);
                    check("byte_enable", 64'(o_be), 64'(ebe));
                    if (wr) check("mem_wdata", o_wdata, ewd);
                end
                if (j == k) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mrd;
                end
                @(negedge clk);
                mem_resp = 1'b0;
            end
            check("rw_drop", 64'({o_read, o_write}), 64'd0);
        end
        waitc = 0;
        while (sb.size() != 0 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        check("rsp_seen", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;

        // Reset holds everything quiet regardless of input activity.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_ready", 64'({r32, r64}), 64'd3);
            check("rst_outs32", 64'(|{v32, rd32, wr32, rdata32, addr32, wdata32, err32, be32}), 64'd0);
            check("rst_outs64", 64'(|{v64, rd64, wr64, rdata64, addr64, wdata64, err64, be64}), 64'd0);
            req_valid  = 1'($urandom_range(0, 1));
            mem_resp   = 1'($urandom_range(0, 1));
            sel        = 1'($urandom_range(0, 1));
            req_addr   = {$urandom, $urandom};
            req_funct3 = 3'($urandom_range(0, 7));
        end
        req_valid = 1'b0; mem_resp = 1'b0; sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'({r32, r64, v32, v64}), 64'hC);

        // XLEN=32, timeout 4
        do_req(0, 0, 3'b000, 64'h103, 0, 3, 64'h80FF_1234, 1, 64'h100, 8'hF, 0, 64'hFFFF_FF80, 2'b00);
        @(negedge clk); @(negedge clk);
        check("rsp_hold", o_rdata, 64'hFFFF_FF80);
        do_req(0, 1, 3'b001, 64'h202, 64'h0000_BEEF, 2, 64'hFFFF_FFFF, 1, 64'h200, 8'hC, 64'hBEEF_0000, 0, 2'b00);
        do_req(0, 0, 3'b010, 64'h101, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        do_req(0, 0, 3'b011, 64'h100, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10);
        do_req(0, 1, 3'b100, 64'h100, 64'h55, 0, 0, 0, 0, 0, 0, 0, 2'b10);
        do_req(0, 0, 3'b111, 64'h101, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10);
        do_req(0, 0, 3'b010, 64'h300, 0, 1, 64'h1111_2222, 1, 64'h300, 8'hF, 0, 64'h1111_2222, 2'b00);
        do_req(0, 0, 3'b010, 64'h300, 0, 0, 0, 1, 64'h300, 8'hF, 0, 0, 2'b11);
        do_req(0, 0, 3'b010, 64'h300, 0, 4, 64'h1234_5678, 1, 64'h300, 8'hF, 0, 64'h1234_5678, 2'b00);
        do_req(0, 0, 3'b101, 64'h402, 0, 2, 64'h9ABC_1234, 1, 64'h400, 8'hF, 0, 64'h0000_9ABC, 2'b00);
        do_req(0, 0, 3'b001, 64'h402, 0, 2, 64'h9ABC_1234, 1, 64'h400, 8'hF, 0, 64'hFFFF_9ABC, 2'b00);
        do_req(0, 0, 3'b100, 64'h401, 0, 1, 64'h0000_A500, 1, 64'h400, 8'hF, 0, 64'h0000_00A5, 2'b00);
        do_req(0, 1, 3'b000, 64'h003, 64'h5A, 1, 0, 1, 64'h0, 8'h8, 64'h5A00_0000, 0, 2'b00);
        do_req(0, 1, 3'b010, 64'h010, 64'hDEAD_BEEF, 3, 0, 1, 64'h10, 8'hF, 64'hDEAD_BEEF, 0, 2'b00);

        // XLEN=64, timeout 16
        do_req(1, 0, 3'b110, 64'h1004, 0, 2, 64'h8000_0001_0000_0000, 1, 64'h1000, 8'hFF, 0, 64'h0000_0000_8000_0001, 2'b00);
        do_req(1, 1, 3'b011, 64'h1008, 64'h1122_3344_5566_7788, 1, 0, 1, 64'h1008, 8'hFF, 64'h1122_3344_5566_7788, 0, 2'b00);
        do_req(1, 0, 3'b010, 64'h1004, 0, 1, 64'h8000_0001_0000_0000, 1, 64'h1000, 8'hFF, 0, 64'hFFFF_FFFF_8000_0001, 2'b00);
        do_req(1, 0, 3'b011, 64'h1000, 0, 3, 64'hCAFE_F00D_0123_4567, 1, 64'h1000, 8'hFF, 0, 64'hCAFE_F00D_0123_4567, 2'b00);
        do_req(1, 0, 3'b011, 64'h1004, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        do_req(1, 0, 3'b111, 64'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10);
        do_req(1, 1, 3'b001, 64'h1006, 64'hABCD, 2, 0, 1, 64'h1000, 8'hC0, 64'hABCD_0000_0000_0000, 0, 2'b00);

        // Reset in the middle of an access drops the request with no response.
        @(negedge clk);
        sel = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 64'h500;
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst_read", 64'(o_read), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_drop", 64'({o_ready, o_read, o_write}), 64'h4);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("midrst_idle", 64'({o_ready, o_valid}), 64'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1);
    end
endmodule
